spd_uart_dump: RTL
==================

Name: spd_uart_dump

Overview:
Downstream consumer of the SPD reader. It accepts one SPD byte at a time as an address/data pair over a valid/ready handshake. Each byte is formatted as an ASCII hex line and sent out of an 8N1 UART TX pin, so a host terminal can dump the DIMM SPD contents. It sits in the SPD bring-up top, clocked from the 100 MHz main clock alongside the reader.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz
BAUD, 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 868 at defaults), must be >= 4

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  reset, synchronous, active-high
i_valid  input  1  SPD byte available
o_ready  output  1  block can accept a byte
i_addr  input  8  SPD byte address
i_data  input  8  SPD byte value
i_last  input  1  marks the final byte of a dump (used only with the optional feature)
o_uart_tx  output  1  UART serial out, idle high
o_busy  output  1  line formatting/transmission in progress

Behaviour:
- Reset: o_uart_tx=1, o_ready=1, o_busy=0. FSM goes to IDLE, baud counter=0, checksum=0. Reset takes effect at the next edge even mid-bit: TX is forced high and any partial line is dropped, not resumed.
- Handshake: a transfer occurs on any edge where i_valid && o_ready. i_addr, i_data and i_last are captured on that edge. o_ready=0 and o_busy=1 from the next cycle. i_valid may stay high while o_ready=0; nothing further is captured.
- Line format per byte: 7 characters, hi(addr), lo(addr), ':' (0x3A), hi(data), lo(data), CR (0x0D), LF (0x0A).
- Nibble encoding: 0-9 -> 0x30-0x39; A-F -> uppercase 0x41-0x46.
- FSM states:
  - IDLE: o_ready=1; on transfer go to LOAD.
  - LOAD: select the next character.
  - START: one bit time of 0.
  - DATA: 8 bits, LSB first.
  - STOP: one bit time of 1.
  - After STOP, return to LOAD for the next character, or go to IDLE after LF.
- Timing:
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Start bit of the first character begins the cycle after the transfer edge (T+1).
  - Characters are back-to-back, with no idle gap between stop and next start.
  - o_ready returns to 1 at cycle T+1+70*CLKS_PER_BIT, i.e. after 7 chars x 10 bits, counting the LOAD cycle inside the first bit time.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; the bit index advances on wrap.
- Back-to-back: if i_valid is held high, the next byte is accepted in the first IDLE cycle, so line start bits are spaced exactly 70*CLKS_PER_BIT+1 cycles apart.
- Any address/data value 0x00-0xFF is legal; no byte is filtered.

Optional Feature:
Macro: SPD_DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of accepted i_data is kept.
  - When the captured i_last=1, the data line is followed immediately by a second line: 'S', ':', hi(sum), lo(sum), CR, LF, i.e. 6 chars.
  - The sum includes the last byte and is cleared to 0 after the summary line.
  - o_ready returns to 1 only after the summary line's LF stop bit, giving 130*CLKS_PER_BIT total.
- Undefined: i_last is ignored, no sum register exists, and every line is 7 chars.

Test Plan:
- BAUD=CLK_FREQ/8, i_addr=0x02, i_data=0x0B, one transfer -> TX decodes "02:0B\r\n". Start bit falls at T+1; every bit is 8 cycles wide; o_ready rises at T+561.
- i_addr=0xFA, i_data=0xCE -> "FA:CE\r\n" with uppercase hex (0x46,0x41,0x3A,0x43,0x45,0x0D,0x0A).
- i_valid held high with 3 bytes queued (0x00/0x92, 0x01/0x10, 0x02/0x0B) -> three lines, none lost or duplicated, start bits 561 cycles apart. i_addr changes while o_ready=0 are ignored.
- i_rst asserted in the middle of the 3rd character's data bits -> o_uart_tx=1 and o_ready=1 on the next edge. A fresh byte 0x05/0x03 then produces a clean "05:03\r\n".
- i_valid=0 for 5000 cycles after reset -> o_uart_tx stays 1, o_busy=0, and no spurious start bit appears.
- With SPD_DUMP_CHECKSUM_EN, bytes 0x92, 0x10, 0x0B, the last with i_last=1 -> three data lines then "S:AD\r\n". A following dump of 0x01 with i_last=1 yields "S:01\r\n", showing the sum was cleared.

Source files
------------

// File: rtl/spd_uart_dump.sv
// spd_uart_dump: turns each accepted SPD address/data byte into an "AA:DD\r\n" ASCII line on an 8N1 UART.
// Define SPD_DUMP_CHECKSUM_EN to append an "S:SS\r\n" running-sum line after a byte flagged with i_last.
module spd_uart_dump #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("spd_uart_dump: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [3:0]       char_idx_q, char_idx_d;
    logic [7:0]       shift_q,    shift_d;
    logic [7:0]       addr_q,     addr_d;
    logic [7:0]       data_q,     data_d;
    logic             tx_q,       tx_d;
    logic             ready_q,    ready_d;
    logic             busy_q,     busy_d;
`ifdef SPD_DUMP_CHECKSUM_EN
    logic             last_q,     last_d;
    logic [7:0]       sum_q,      sum_d;
`endif

    logic       bit_wrap;
    logic       line_done;
    logic [7:0] char_sel;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign bit_wrap = (cnt_q == CNT_MAX);

    // Character 6 is the data line's LF; 7..12 form the optional summary line.
`ifdef SPD_DUMP_CHECKSUM_EN
    assign line_done = (char_idx_q == 4'd12) || ((char_idx_q == 4'd6) && !last_q);
`else
    assign line_done = (char_idx_q == 4'd6);
    logic unused_last;
    assign unused_last = i_last;
`endif

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
        char_sel = CH_LF;
        case (char_idx_q)
            4'd0:    char_sel = hex_ascii(addr_q[7:4]);
            4'd1:    char_sel = hex_ascii(addr_q[3:0]);
            4'd2:    char_sel = CH_COLON;
            4'd3:    char_sel = hex_ascii(data_q[7:4]);
            4'd4:    char_sel = hex_ascii(data_q[3:0]);
            4'd5:    char_sel = CH_CR;
`ifdef SPD_DUMP_CHECKSUM_EN
            4'd7:    char_sel = 8'h53;
            4'd8:    char_sel = CH_COLON;
            4'd9:    char_sel = hex_ascii(sum_q[7:4]);
            4'd10:   char_sel = hex_ascii(sum_q[3:0]);
            4'd11:   char_sel = CH_CR;
`endif
            default: char_sel = CH_LF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
`ifdef SPD_DUMP_CHECKSUM_EN
        last_d     = last_q;
        sum_d      = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                // The start bit is driven on the accept edge; the LOAD cycle is its first clock.
                if (i_valid && ready_q) begin
                    addr_d     = i_addr;
                    data_d     = i_data;
`ifdef SPD_DUMP_CHECKSUM_EN
                    last_d     = i_last;
                    sum_d      = sum_q + i_data;
`endif
                    char_idx_d = 4'd0;
                    cnt_d      = '0;
                    tx_d       = 1'b0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_LOAD;
                end
            end

            S_LOAD: begin
                shift_d = char_sel;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_START;
            end

            S_START: begin
                if (bit_wrap) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_wrap) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (bit_wrap) begin
                    cnt_d = '0;
                    if (line_done) begin
`ifdef SPD_DUMP_CHECKSUM_EN
                        if (char_idx_q == 4'd12) begin
                            sum_d = 8'h00;
                        end
`endif
                        char_idx_d = 4'd0;
                        ready_d    = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        char_idx_d = char_idx_q + 4'd1;
                        tx_d       = 1'b0;
                        state_d    = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            char_idx_q <= 4'd0;
            shift_q    <= 8'h00;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
`ifdef SPD_DUMP_CHECKSUM_EN
            last_q     <= 1'b0;
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
`ifdef SPD_DUMP_CHECKSUM_EN
            last_q     <= last_d;
            sum_q      <= sum_d;
`endif
        end
    end

    assign o_uart_tx = tx_q;
    assign o_ready   = ready_q;
    assign o_busy    = busy_q;

endmodule
